// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unified_mem_arb_pkg;

  localparam int DEFAULT_AW             = 32;
  localparam int DEFAULT_DW             = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Arbiter state: idle, or owning the RAM on behalf of one requester.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } arb_state_t;

  // Requester IDs.
  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // Which requester owns the RAM in a given busy state.
  function automatic logic state_owner(input arb_state_t s);
    return (s == MEM_BUSY) ? REQ_MEM : REQ_IF;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// RAM wait watchdog: counts busy cycles without ack, flags expiry (only built with ARB_TIMEOUT_EN).
// Latency: expired is combinational in the TIMEOUT_CYCLES-th busy cycle without ack.
// Backpressure: none; the counter restarts whenever the RAM acks or the arbiter goes idle.
`ifdef ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Expiry fires in the last allowed wait cycle; an ack in that same cycle wins.
  assign expired = busy & ~ack & (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter: counts busy cycles, restarts on ack, idle or expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!busy || ack || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported RAM between fetch (IF) and load/store (MEM); MEM has fixed priority.
// Latency: request in cycle N, RAM req from N+1, done/rdata in N+2 for a zero-wait RAM.
// Backpressure: stall_if/stall_mem hold the pipeline until the owner's done; optional ARB_TIMEOUT_EN aborts hung RAM accesses.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int AW             = DEFAULT_AW,
  parameter int DW             = DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_adv,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          stall_if,
  input  logic          mem_rd_en,
  input  logic          mem_wr_en,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          stall_mem,
  output logic          ram_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ack,
  output logic          timeout_err
);

  arb_state_t st, st_nxt;
  logic       if_served, mem_served;
  logic       if_elig, mem_elig;
  logic       grant_if, grant_mem;
  logic       busy, timed_out, xfer_end;

  // Eligibility is gated by reset so stalls drop the instant reset asserts.
  // Served flags stop a held request from being serviced twice while the pipeline is frozen.
  assign if_elig   = reset & if_req & ~if_served & ~if_done;
  assign mem_elig  = reset & (mem_rd_en | mem_wr_en) & ~mem_served & ~mem_done;

  assign busy      = (st != IDLE);
  assign ram_req   = busy;
  assign stall_if  = if_elig  | (st == IF_BUSY);
  assign stall_mem = mem_elig | (st == MEM_BUSY);

`ifdef ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .ack     (ram_ack),
    .expired (timed_out)
  );
`else
  logic unused_cfg;
  assign timed_out  = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  assign xfer_end = busy & (ram_ack | timed_out);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next state and grant decode: MEM (older instruction) wins over IF.
  always_comb begin
    st_nxt    = st;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    unique case (st)
      IDLE: begin
        if (mem_elig) begin
          st_nxt    = MEM_BUSY;
          grant_mem = 1'b1;
        end else if (if_elig) begin
          st_nxt   = IF_BUSY;
          grant_if = 1'b1;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (ram_ack | timed_out) begin
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Latch the RAM command on the grant edge so it stays stable while the RAM is waited on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else if (grant_mem) begin
      ram_addr  <= mem_addr;
      ram_wdata <= mem_wdata;
      ram_we    <= mem_wr_en;
    end else if (grant_if) begin
      ram_addr  <= if_addr;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end
  end

  // Completion: one-cycle done to the owner, read data captured for loads/fetches, zeroed on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      if (xfer_end) begin
        if (state_owner(st) == REQ_MEM) begin
          mem_done <= 1'b1;
          if (timed_out) begin
            mem_rdata <= '0;
          end else if (!ram_we) begin
            mem_rdata <= ram_rdata;
          end
        end else begin
          if_done  <= 1'b1;
          if_rdata <= timed_out ? '0 : ram_rdata;
        end
      end
    end
  end

  // Served flags: set by done, cleared when the pipeline advances (advance wins if simultaneous).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_served  <= 1'b0;
      mem_served <= 1'b0;
    end else begin
      if_served  <= pipe_adv ? 1'b0 : (if_served  | if_done);
      mem_served <= pipe_adv ? 1'b0 : (mem_served | mem_done);
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (timed_out) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized IF/MEM pairs against a RAM model.
// Latency: expected done cycles come from a transaction-level timing model.
// Backpressure: RAM ack delay is programmable per transaction; hang mode withholds ack.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_adv;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        stall_if;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, stall_mem;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // RAM model state
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  int          ack_dly [64];
  logic [5:0]  txn_idx;
  int          wcnt;
  bit          ram_hang = 1'b0;
  logic [31:0] salt;
  logic [31:0] log_addr [$];

  // Observations from run_pair
  int          t_start, t_if, t_mem, t_req;
  int          n_if_done, n_mem_done, n_we_cyc;
  logic [31:0] obs_if_rdata, obs_mem_rdata, obs_req_addr;
  logic        obs_stall_if, obs_stall_if0, obs_stall_mem0, obs_req0;

  // Expected rdata registers of the reference model
  logic [31:0] exp_if_rd, exp_mem_rd;

  unified_mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .pipe_adv(pipe_adv),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .stall_if(stall_if),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_mem(stall_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] iv;
    iv = 32'(i);
    return {salt[23:0], iv[7:0]};
  endfunction

  // RAM: ack after ack_dly[txn] wait cycles (0 = ack in first req cycle), writes on ack.
  assign ram_ack   = ram_req && !ram_hang && (wcnt >= ack_dly[txn_idx]);
  assign ram_rdata = ram_mem[ram_addr[9:2]];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      wcnt    <= 0;
      txn_idx <= '0;
    end else begin
      if (ram_req && ram_ack) begin
        log_addr.push_back(ram_addr);
        if (ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
        txn_idx <= txn_idx + 6'd1;
        wcnt    <= 0;
      end else if (ram_req) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
      end
    end
  end

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  // Drives one IF and/or MEM request in the same cycle, holds each until its done, records timing.
  task automatic run_pair(input bit do_if, input bit do_mem, input bit we,
                          input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
    bit if_seen, mem_seen;
    log_addr.delete();
    @(posedge clk); #1;
    t_start   = cyc;
    if_req    = do_if;
    if_addr   = ia;
    mem_rd_en = do_mem & ~we;
    mem_wr_en = do_mem & we;
    mem_addr  = ma;
    mem_wdata = wd;
    if_seen   = !do_if;
    mem_seen  = !do_mem;
    t_if = -1; t_mem = -1; t_req = -1;
    n_if_done = 0; n_mem_done = 0; n_we_cyc = 0;
    for (int k = 0; k < 60 && !(if_seen && mem_seen); k++) begin
      @(negedge clk);
      if (k == 0) begin
        obs_stall_if0  = stall_if;
        obs_stall_mem0 = stall_mem;
        obs_req0       = ram_req;
      end
      if (ram_req && t_req < 0) begin
        t_req        = cyc;
        obs_req_addr = ram_addr;
      end
      if (ram_req && ram_we && ram_wdata == wd) n_we_cyc++;
      if (if_done) begin
        n_if_done++;
        if (!if_seen) begin
          t_if         = cyc;
          obs_if_rdata = if_rdata;
          obs_stall_if = stall_if;
        end
        if_seen = 1'b1;
      end
      if (mem_done) begin
        n_mem_done++;
        if (!mem_seen) begin
          t_mem         = cyc;
          obs_mem_rdata = mem_rdata;
        end
        mem_seen = 1'b1;
      end
      @(posedge clk); #1;
      if (if_seen) if_req = 1'b0;
      if (mem_seen) begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
      end
    end
    if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    // Watch a little longer for spurious extra done pulses.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_done) n_if_done++;
      if (mem_done) n_mem_done++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({if_done, mem_done, stall_if, stall_mem, ram_req, ram_we, timeout_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {if_done, mem_done, stall_if, stall_mem, ram_req, ram_we, timeout_err});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0", ram_addr, ram_wdata, if_rdata, mem_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    ref_init();
    exp_if_rd = '0;
    exp_mem_rd = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_if_fetch();
    ack_dly[txn_idx] = 0;
    exp_if_rd = ref_mem[8'h10];
    run_pair(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0);
    n_cmp++;
    if (obs_stall_if0 !== 1'b1 || obs_req0 !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_req_cycle: stall_if=%b ram_req=%b expected 1 0", obs_stall_if0, obs_req0);
    end
    n_cmp++;
    if (t_req !== t_start + 1) begin
      n_fail++;
      $display("FAIL fetch_ram_req_time: got %0d expected %0d", t_req - t_start, 1);
    end
    n_cmp++;
    if (obs_req_addr !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL fetch_ram_addr: got %h expected %h", obs_req_addr, 32'h40);
    end
    n_cmp++;
    if (t_if !== t_start + 2) begin
      n_fail++;
      $display("FAIL fetch_done_time: got %0d expected %0d", t_if - t_start, 2);
    end
    n_cmp++;
    if (obs_if_rdata !== exp_if_rd) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h expected %h", obs_if_rdata, exp_if_rd);
    end
    n_cmp++;
    if (obs_stall_if !== 1'b0 || n_if_done !== 1) begin
      n_fail++;
      $display("FAIL fetch_done_stall: stall_if=%b pulses=%0d expected 0 1", obs_stall_if, n_if_done);
    end
  endtask

  task automatic test_both_req();
    logic [31:0] a0, a1;
    ack_dly[txn_idx] = 0;
    ack_dly[txn_idx + 6'd1] = 0;
    exp_mem_rd = ref_mem[8'h80];
    exp_if_rd  = ref_mem[8'h40];
    run_pair(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'h0);
    a0 = (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF;
    a1 = (log_addr.size() > 1) ? log_addr[1] : 32'hFFFF_FFFF;
    n_cmp++;
    if (obs_stall_if0 !== 1'b1 || obs_stall_mem0 !== 1'b1) begin
      n_fail++;
      $display("FAIL both_stalls: got %b%b expected 11", obs_stall_if0, obs_stall_mem0);
    end
    n_cmp++;
    if (a0 !== 32'h200 || a1 !== 32'h100 || log_addr.size() != 2) begin
      n_fail++;
      $display("FAIL both_order: got %h,%h (n=%0d) expected 200,100 (n=2)", a0, a1, log_addr.size());
    end
    n_cmp++;
    if (t_mem !== t_start + 2 || t_if !== t_start + 4) begin
      n_fail++;
      $display("FAIL both_times: mem %0d if %0d expected 2 4", t_mem - t_start, t_if - t_start);
    end
    n_cmp++;
    if (obs_mem_rdata !== exp_mem_rd || obs_if_rdata !== exp_if_rd) begin
      n_fail++;
      $display("FAIL both_rdata: got %h %h expected %h %h", obs_mem_rdata, obs_if_rdata, exp_mem_rd, exp_if_rd);
    end
  endtask

  task automatic test_store();
    ack_dly[txn_idx] = 2;
    ref_mem[8'h20] = 32'hDEAD_BEEF;
    run_pair(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0080, 32'hDEAD_BEEF);
    n_cmp++;
    if (n_we_cyc !== 3) begin
      n_fail++;
      $display("FAIL store_we_cycles: got %0d expected 3", n_we_cyc);
    end
    n_cmp++;
    if (n_mem_done !== 1 || t_mem !== t_start + 4) begin
      n_fail++;
      $display("FAIL store_done: pulses %0d at %0d expected 1 at 4", n_mem_done, t_mem - t_start);
    end
    n_cmp++;
    if (obs_mem_rdata !== exp_mem_rd) begin
      n_fail++;
      $display("FAIL store_rdata_kept: got %h expected %h", obs_mem_rdata, exp_mem_rd);
    end
    ack_dly[txn_idx] = 1;
    exp_mem_rd = ref_mem[8'h20];
    run_pair(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0080, 32'h0);
    n_cmp++;
    if (obs_mem_rdata !== exp_mem_rd) begin
      n_fail++;
      $display("FAIL store_readback: got %h expected %h", obs_mem_rdata, exp_mem_rd);
    end
  endtask

  task automatic test_hold_no_regrant();
    int t_d, t_p, t_d2, regrant, stall_seen;
    ack_dly[txn_idx] = 0;
    ack_dly[txn_idx + 6'd1] = 0;
    exp_mem_rd = ref_mem[8'h03];
    log_addr.delete();
    @(posedge clk); #1;
    pipe_adv = 1'b0;
    mem_rd_en = 1'b1;
    mem_addr = 32'h0000_000C;
    t_d = -1;
    for (int k = 0; k < 20 && t_d < 0; k++) begin
      @(negedge clk);
      if (mem_done) t_d = cyc;
      @(posedge clk); #1;
    end
    regrant = 0;
    stall_seen = 0;
    // The cycle after done is already under way; observe it plus four more.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (ram_req) regrant++;
      if (stall_mem) stall_seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (t_d < 0 || regrant != 0 || stall_seen != 0 || log_addr.size() != 1) begin
      n_fail++;
      $display("FAIL hold_no_regrant: done=%0d req_cycles=%0d stall_cycles=%0d grants=%0d expected 0 0 1",
               t_d, regrant, stall_seen, log_addr.size());
    end
    pipe_adv = 1'b1;
    t_p = cyc;
    @(posedge clk); #1;
    pipe_adv = 1'b0;
    t_d2 = -1;
    for (int k = 0; k < 20 && t_d2 < 0; k++) begin
      @(negedge clk);
      if (mem_done) begin
        t_d2 = cyc;
        obs_mem_rdata = mem_rdata;
      end
      @(posedge clk); #1;
    end
    mem_rd_en = 1'b0;
    pipe_adv = 1'b1;
    n_cmp++;
    if (t_d2 !== t_p + 3 || log_addr.size() != 2) begin
      n_fail++;
      $display("FAIL hold_regrant_after_adv: got %0d grants=%0d expected 3 grants=2", t_d2 - t_p, log_addr.size());
    end
    n_cmp++;
    if (obs_mem_rdata !== exp_mem_rd) begin
      n_fail++;
      $display("FAIL hold_rdata: got %h expected %h", obs_mem_rdata, exp_mem_rd);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    ram_hang = 1'b1;
    @(posedge clk); #1;
    mem_rd_en = 1'b1;
    mem_addr = 32'h10;
    if_req = 1'b1;
    if_addr = 32'h20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ram_req !== 1'b1 || stall_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: ram_req=%b stall_mem=%b expected 1 1", ram_req, stall_mem);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ram_req, stall_mem, stall_if, mem_done, if_done} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got %b expected 00000", {ram_req, stall_mem, stall_if, mem_done, if_done});
    end
    @(posedge clk); #1;
    mem_rd_en = 1'b0;
    if_req = 1'b0;
    ram_hang = 1'b0;
    reset = 1'b1;
    ref_init();
    exp_mem_rd = '0;
    exp_if_rd = '0;
    @(negedge clk);
    n_cmp++;
    if ({mem_rdata, if_rdata} !== 64'b0 || ram_req !== 1'b0 || stall_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: rdata %h %h ram_req=%b stall_mem=%b expected 0", mem_rdata, if_rdata, ram_req, stall_mem);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit          do_if, do_mem, we;
    logic [31:0] ia, ma, wd, a0, a1;
    int          di, dm, e_mem, e_if;
    logic [5:0]  k;
    for (int it = 0; it < 40; it++) begin
      do_if  = 1'($urandom_range(0, 1));
      do_mem = 1'($urandom_range(0, 1));
      if (!do_if && !do_mem) do_if = 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = 32'($urandom_range(0, 15)) << 2;
      ma = 32'($urandom_range(0, 15)) << 2;
      wd = $urandom;
      di = $urandom_range(0, 3);
      dm = $urandom_range(0, 3);
      k = txn_idx;
      ack_dly[k] = do_mem ? dm : di;
      ack_dly[k + 6'd1] = di;
      // Reference: MEM operation happens first, then the fetch sees memory after it.
      if (do_mem) begin
        if (we) ref_mem[ma[9:2]] = wd;
        else exp_mem_rd = ref_mem[ma[9:2]];
      end
      if (do_if) exp_if_rd = ref_mem[ia[9:2]];
      run_pair(do_if, do_mem, we, ia, ma, wd);
      e_mem = t_start + 2 + dm;
      e_if  = (do_mem ? e_mem : t_start) + 2 + di;
      a0 = (log_addr.size() > 0) ? log_addr[0] : 32'hFFFF_FFFF;
      a1 = (log_addr.size() > 1) ? log_addr[1] : 32'hFFFF_FFFF;
      n_cmp++;
      if (log_addr.size() != (int'(do_if) + int'(do_mem)) || a0 !== (do_mem ? ma : ia) || (do_if && do_mem && a1 !== ia)) begin
        n_fail++;
        $display("FAIL rnd_order it%0d: got %h,%h n=%0d expected first %h", it, a0, a1, log_addr.size(), do_mem ? ma : ia);
      end
      if (do_mem) begin
        n_cmp++;
        if (t_mem !== e_mem || obs_mem_rdata !== exp_mem_rd || n_mem_done !== 1) begin
          n_fail++;
          $display("FAIL rnd_mem it%0d: t=%0d rd=%h n=%0d expected t=%0d rd=%h n=1",
                   it, t_mem, obs_mem_rdata, n_mem_done, e_mem, exp_mem_rd);
        end
      end
      if (do_if) begin
        n_cmp++;
        if (t_if !== e_if || obs_if_rdata !== exp_if_rd || n_if_done !== 1) begin
          n_fail++;
          $display("FAIL rnd_if it%0d: t=%0d rd=%h n=%0d expected t=%0d rd=%h n=1",
                   it, t_if, obs_if_rdata, n_if_done, e_if, exp_if_rd);
        end
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int nreq, t_d;
    logic [31:0] rd;
    logic req_at_done;
    ram_hang = 1'b1;
    @(posedge clk); #1;
    t_start = cyc;
    mem_rd_en = 1'b1;
    mem_addr = 32'h44;
    nreq = 0;
    t_d = -1;
    rd = 32'hFFFF_FFFF;
    req_at_done = 1'b1;
    for (int k = 0; k < 40 && t_d < 0; k++) begin
      @(negedge clk);
      if (ram_req) nreq++;
      if (mem_done) begin
        t_d = cyc;
        rd = mem_rdata;
        req_at_done = ram_req;
      end
      @(posedge clk); #1;
    end
    mem_rd_en = 1'b0;
    ram_hang = 1'b0;
    n_cmp++;
    if (nreq != 8 || t_d !== t_start + 9 || req_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: req_cycles=%0d done_at=%0d ram_req=%b expected 8 9 0", nreq, t_d - t_start, req_at_done);
    end
    n_cmp++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_rdata: got %h expected 0", rd);
    end
    exp_mem_rd = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
    end
    @(posedge clk); #1;
  endtask
`else
  task automatic test_no_timeout();
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_tied: got %b expected 0", timeout_err);
    end
  endtask
`endif

  initial begin
    salt      = $urandom | 32'h0000_0100;
    reset     = 1'b0;
    pipe_adv  = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < 64; i++) ack_dly[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_if_fetch();
    test_both_req();
    test_store();
    test_hold_no_regrant();
    test_reset_mid();
    test_random();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
